// File: rtl/tag_req_extractor_pkg.sv
// Shared types and default widths for the tag request extractor and its metadata FIFO.
package tag_req_extractor_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefIdWidth   = 4;
  localparam int unsigned DefTidWidth  = 6;
  localparam int unsigned DefDepth     = 64;

  typedef enum logic {
    ArbFixed = 1'b0,
    ArbRr    = 1'b1
  } arb_mode_e;

  // Field order matches the FIFO word layout {tid, is_wr, axi_id, addr}.
  typedef struct packed {
    logic [DefTidWidth-1:0]  tid;
    logic                    is_wr;
    logic [DefIdWidth-1:0]   axi_id;
    logic [DefAddrWidth-1:0] addr;
  } meta_entry_t;

endpackage

// File: rtl/tag_req_extractor_if.sv
// Processor request, memory tag-read and metadata-drain signals of the tag request extractor.
interface tag_req_extractor_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned TID_WIDTH  = 6,
  parameter int unsigned FIFO_DEPTH = 64
);
  localparam int unsigned MetaWidth  = TID_WIDTH + ID_WIDTH + ADDR_WIDTH + 1;
  localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;

  logic [ID_WIDTH-1:0]   arid_i;
  logic [ADDR_WIDTH-1:0] araddr_i;
  logic                  arvalid_i;
  logic                  arready_o;
  logic [ID_WIDTH-1:0]   awid_i;
  logic [ADDR_WIDTH-1:0] awaddr_i;
  logic                  awvalid_i;
  logic                  awready_o;
  logic [ID_WIDTH-1:0]   arid_o;
  logic [ADDR_WIDTH-1:0] araddr_o;
  logic [7:0]            arlen_o;
  logic                  arvalid_o;
  logic                  arready_i;
  logic                  meta_aempty_o;
  logic                  meta_empty_o;
  logic                  meta_rden_i;
  logic [MetaWidth-1:0]  meta_rdata_o;
  logic [CountWidth-1:0] meta_count_o;
  logic                  overflow_o;

  modport master (
    output arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i, arready_i, meta_rden_i,
    input  arready_o, awready_o, arid_o, araddr_o, arlen_o, arvalid_o, meta_aempty_o,
           meta_empty_o, meta_rdata_o, meta_count_o, overflow_o
  );

  modport slave (
    input  arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i, arready_i, meta_rden_i,
    output arready_o, awready_o, arid_o, araddr_o, arlen_o, arvalid_o, meta_aempty_o,
           meta_empty_o, meta_rdata_o, meta_count_o, overflow_o
  );

endinterface

// File: rtl/tag_req_extractor_meta_fifo.sv
// Synchronous show-ahead FIFO with occupancy count, almost-full/empty thresholds and
// a sticky overflow flag. Depth must be a power of two, at least 2.
module tag_req_extractor_meta_fifo #(
  parameter int unsigned Width     = 43,
  parameter int unsigned Depth     = 64,
  parameter int unsigned AfullThr  = 62,
  parameter int unsigned AemptyThr = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic [$clog2(Depth):0]     count,
  output logic                       empty,
  output logic                       aempty,
  output logic                       afull,
  output logic                       overflow
);
  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned CountWidth = PtrWidth + 1;

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountWidth-1:0] count_q;
  logic                  overflow_q;
  logic [31:0]           count_ext;
  logic                  is_full, do_pop, do_push;

  assign count_ext = 32'(count_q);
  assign is_full   = (count_ext == Depth);
  assign do_pop    = pop & (count_q != '0);
  // A pop in the same cycle frees the slot, so a push on full is still legal then.
  assign do_push   = push & (~is_full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CountWidth'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CountWidth'(1);
      end
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  assign rdata    = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign aempty   = (count_ext <= AemptyThr);
  assign afull    = (count_ext >= AfullThr);
  assign overflow = overflow_q;

endmodule

// File: rtl/tag_req_extractor.sv
// Arbitrates processor AR/AW requests, tags each with a wrapping TID, issues a
// line-aligned tag read to memory and queues request metadata for the tag comparator.
module tag_req_extractor
  import tag_req_extractor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned ID_WIDTH     = DefIdWidth,
  parameter int unsigned MEM_ID       = 0,
  parameter int unsigned TID_WIDTH    = DefTidWidth,
  parameter int unsigned OFFSET_WIDTH = 6,
  parameter int unsigned TAG_LEN      = 0,
  parameter int unsigned FIFO_DEPTH   = DefDepth,
  parameter int unsigned AFULL_THR    = 62,
  parameter int unsigned AEMPTY_THR   = 2,
  parameter arb_mode_e   ARB_MODE     = ArbFixed
) (
  input logic                clk,
  input logic                rst,
  tag_req_extractor_if.slave bus
);
  localparam int unsigned MetaWidth = TID_WIDTH + ID_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LineMask = {ADDR_WIDTH{1'b1}} << OFFSET_WIDTH;

  logic                  a_full, can_acc, both_valid, grant_aw, acc_ar, acc_aw, accept;
  logic                  arvalid_q, rr_aw_q;
  logic [ADDR_WIDTH-1:0] araddr_q, req_addr;
  logic [ID_WIDTH-1:0]   req_id;
  logic [TID_WIDTH-1:0]  tid_q;
  logic [MetaWidth-1:0]  meta_wdata;

  assign both_valid = bus.arvalid_i & bus.awvalid_i;

  always_comb begin
    grant_aw = bus.awvalid_i & ~bus.arvalid_i;
    if (ARB_MODE == ArbRr && both_valid) grant_aw = rr_aw_q;
  end

  // Reset gates acceptance so no handshake completes in the reset cycle.
  assign can_acc = ~rst & ~a_full & (~arvalid_q | bus.arready_i);
  assign acc_ar  = can_acc & bus.arvalid_i & ~grant_aw;
  assign acc_aw  = can_acc & bus.awvalid_i & grant_aw;
  assign accept  = acc_ar | acc_aw;

  assign req_addr   = acc_aw ? bus.awaddr_i : bus.araddr_i;
  assign req_id     = acc_aw ? bus.awid_i : bus.arid_i;
  assign meta_wdata = {tid_q, acc_aw, req_id, req_addr};

  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      tid_q     <= '0;
      rr_aw_q   <= 1'b0;
    end else begin
      if (accept) begin
        arvalid_q <= 1'b1;
        araddr_q  <= req_addr & LineMask;
        tid_q     <= tid_q + TID_WIDTH'(1);
      end else if (bus.arready_i) begin
        arvalid_q <= 1'b0;
      end
      if (accept && both_valid) rr_aw_q <= ~rr_aw_q;
    end
  end

  assign bus.arready_o = acc_ar;
  assign bus.awready_o = acc_aw;
  assign bus.arid_o    = ID_WIDTH'(MEM_ID);
  assign bus.arlen_o   = 8'(TAG_LEN);
  assign bus.arvalid_o = arvalid_q;
  assign bus.araddr_o  = araddr_q;

  tag_req_extractor_meta_fifo #(
    .Width     (MetaWidth),
    .Depth     (FIFO_DEPTH),
    .AfullThr  (AFULL_THR),
    .AemptyThr (AEMPTY_THR)
  ) u_meta_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .wdata    (meta_wdata),
    .pop      (bus.meta_rden_i),
    .rdata    (bus.meta_rdata_o),
    .count    (bus.meta_count_o),
    .empty    (bus.meta_empty_o),
    .aempty   (bus.meta_aempty_o),
    .afull    (a_full),
    .overflow (bus.overflow_o)
  );

endmodule

// File: tb/tb_tag_req_extractor.sv
// Scoreboard bench for tag_req_extractor in round-robin mode with default sizing.
module tb_tag_req_extractor;
  import tag_req_extractor_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned TW = 6;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tag_req_extractor_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .TID_WIDTH(TW), .FIFO_DEPTH(DEPTH)) bus ();

  tag_req_extractor #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_ID(0), .TID_WIDTH(TW), .OFFSET_WIDTH(6), .TAG_LEN(0),
    .FIFO_DEPTH(DEPTH), .AFULL_THR(62), .AEMPTY_THR(2), .ARB_MODE(ArbRr)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  meta_entry_t exp_q[$];
  logic [TW-1:0] b_tid;
  int b_count;
  logic s_arready, s_awready;
  meta_entry_t s_head;

  // One clock of stimulus; readies and head are sampled just before the active edge.
  task automatic cycle(input logic arv, input logic [AW-1:0] ara, input logic [IW-1:0] arid,
                       input logic awv, input logic [AW-1:0] awa, input logic [IW-1:0] awid,
                       input logic rdy, input logic rden);
    @(negedge clk);
    bus.arvalid_i = arv; bus.araddr_i = ara; bus.arid_i = arid;
    bus.awvalid_i = awv; bus.awaddr_i = awa; bus.awid_i = awid;
    bus.arready_i = rdy; bus.meta_rden_i = rden;
    #1;
    s_arready = bus.arready_o;
    s_awready = bus.awready_o;
    s_head    = bus.meta_rdata_o;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_accept(input logic is_wr, input logic [IW-1:0] id, input logic [AW-1:0] a);
    meta_entry_t e;
    e.tid = b_tid; e.is_wr = is_wr; e.axi_id = id; e.addr = a;
    exp_q.push_back(e);
    b_tid = b_tid + 1'b1;
    b_count++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, '0, '0, 0, '0, '0, 1, 0);
    rst = 1'b0;
    exp_q.delete();
    b_tid = '0;
    b_count = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1, 32'h40, 4'h1, 1, 32'h80, 4'h2, 1, 1);
    vectors++;
    if ({s_arready, s_awready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready: got %b want 00", {s_arready, s_awready});
    end
    rst = 1'b0;
    exp_q.delete(); b_tid = '0; b_count = 0;
    vectors++;
    if ({bus.arvalid_o, bus.meta_empty_o, bus.meta_aempty_o, bus.overflow_o} !== 4'b0110) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0110",
               {bus.arvalid_o, bus.meta_empty_o, bus.meta_aempty_o, bus.overflow_o});
    end
    vectors++;
    if (bus.meta_count_o !== 7'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d want 0", bus.meta_count_o);
    end
    vectors++;
    if ({bus.arid_o, bus.arlen_o} !== 12'h000) begin
      miscompares++; $display("FAIL reset_arid_arlen: got %h want 000", {bus.arid_o, bus.arlen_o});
    end
  endtask

  task automatic test_single_ar();
    meta_entry_t e;
    cycle(1, 32'h0000_1234, 4'h3, 0, '0, '0, 1, 0);
    vectors++;
    if ({s_arready, s_awready} !== 2'b10) begin
      miscompares++; $display("FAIL single_ready: got %b want 10", {s_arready, s_awready});
    end
    expect_accept(1'b0, 4'h3, 32'h0000_1234);
    vectors++;
    if ({bus.arvalid_o, bus.araddr_o} !== {1'b1, 32'h0000_1200}) begin
      miscompares++;
      $display("FAIL single_tagread: got %b/%h want 1/00001200", bus.arvalid_o, bus.araddr_o);
    end
    vectors++;
    if (bus.meta_rdata_o !== exp_q[0]) begin
      miscompares++; $display("FAIL single_head: got %h want %h", bus.meta_rdata_o, exp_q[0]);
    end
    vectors++;
    if ({bus.meta_count_o, bus.meta_empty_o} !== {7'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_count: got %0d/%b want 1/0", bus.meta_count_o, bus.meta_empty_o);
    end
    cycle(0, '0, '0, 0, '0, '0, 1, 1);
    e = exp_q.pop_front(); b_count--;
    vectors++;
    if (s_head !== e) begin
      miscompares++; $display("FAIL single_pop: got %h want %h", s_head, e);
    end
    vectors++;
    if ({bus.meta_empty_o, bus.arvalid_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_drained: got %b want 10", {bus.meta_empty_o, bus.arvalid_o});
    end
  endtask

  task automatic test_round_robin();
    meta_entry_t e;
    logic [AW-1:0] ara, awa;
    logic g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ara = 32'h1000 + 32'(i * 64) + 32'h5;
      awa = 32'h8000 + 32'(i * 64) + 32'h9;
      g = (i % 2) == 1;
      cycle(1, ara, 4'h1, 1, awa, 4'h2, 1, 0);
      vectors++;
      if ({s_arready, s_awready} !== {~g, g}) begin
        miscompares++; $display("FAIL rr_grant%0d: got %b want %b", i, {s_arready, s_awready}, {~g, g});
      end
      expect_accept(g, g ? 4'h2 : 4'h1, g ? awa : ara);
      vectors++;
      if (bus.araddr_o !== ((g ? awa : ara) & 32'hFFFF_FFC0)) begin
        miscompares++; $display("FAIL rr_araddr%0d: got %h", i, bus.araddr_o);
      end
    end
    while (exp_q.size() > 0) begin
      cycle(0, '0, '0, 0, '0, '0, 1, 1);
      e = exp_q.pop_front(); b_count--;
      vectors++;
      if (s_head !== e) begin
        miscompares++; $display("FAIL rr_order: got %h want %h", s_head, e);
      end
    end
  endtask

  task automatic test_backpressure();
    meta_entry_t e;
    cycle(1, 32'h2040, 4'h5, 0, '0, '0, 0, 0);
    vectors++;
    if ({s_arready, s_awready} !== 2'b10) begin
      miscompares++; $display("FAIL bp_first: got %b want 10", {s_arready, s_awready});
    end
    expect_accept(1'b0, 4'h5, 32'h2040);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h3007, 4'h6, 1, 32'h4000, 4'h7, 0, 0);
      vectors++;
      if ({s_arready, s_awready} !== 2'b00) begin
        miscompares++; $display("FAIL bp_held%0d: got %b want 00", i, {s_arready, s_awready});
      end
      vectors++;
      if ({bus.arvalid_o, bus.araddr_o} !== {1'b1, 32'h2040}) begin
        miscompares++;
        $display("FAIL bp_stable%0d: got %b/%h want 1/00002040", i, bus.arvalid_o, bus.araddr_o);
      end
    end
    cycle(1, 32'h3007, 4'h6, 1, 32'h4000, 4'h7, 1, 0);
    vectors++;
    if ({s_arready, s_awready} !== 2'b10) begin
      miscompares++; $display("FAIL bp_release: got %b want 10", {s_arready, s_awready});
    end
    expect_accept(1'b0, 4'h6, 32'h3007);
    vectors++;
    if (bus.araddr_o !== 32'h3000) begin
      miscompares++; $display("FAIL bp_next_addr: got %h want 00003000", bus.araddr_o);
    end
    cycle(0, '0, '0, 0, '0, '0, 1, 0);
    vectors++;
    if (bus.arvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL bp_drop_valid: got %b want 0", bus.arvalid_o);
    end
    while (exp_q.size() > 0) begin
      cycle(0, '0, '0, 0, '0, '0, 1, 1);
      e = exp_q.pop_front(); b_count--;
      vectors++;
      if (s_head !== e) begin
        miscompares++; $display("FAIL bp_order: got %h want %h", s_head, e);
      end
    end
  endtask

  task automatic test_almost_full();
    meta_entry_t e;
    do_reset();
    for (int i = 0; i < 62; i++) begin
      cycle(1, 32'(i * 4), IW'(i), 0, '0, '0, 1, 0);
      vectors++;
      if (s_arready !== 1'b1) begin
        miscompares++; $display("FAIL af_fill%0d: got %b want 1", i, s_arready);
      end
      expect_accept(1'b0, IW'(i), 32'(i * 4));
    end
    vectors++;
    if (bus.meta_count_o !== 7'd62) begin
      miscompares++; $display("FAIL af_count62: got %0d want 62", bus.meta_count_o);
    end
    cycle(1, 32'hABC0, 4'h1, 1, 32'hDEF0, 4'h2, 1, 0);
    vectors++;
    if ({s_arready, s_awready} !== 2'b00) begin
      miscompares++; $display("FAIL af_blocked: got %b want 00", {s_arready, s_awready});
    end
    cycle(1, 32'hABC0, 4'h1, 1, 32'hDEF0, 4'h2, 1, 1);
    e = exp_q.pop_front(); b_count--;
    vectors++;
    if ({s_arready, s_awready} !== 2'b00 || s_head !== e) begin
      miscompares++; $display("FAIL af_pop: got %b/%h want 00/%h", {s_arready, s_awready}, s_head, e);
    end
    vectors++;
    if (bus.meta_count_o !== 7'd61) begin
      miscompares++; $display("FAIL af_count61: got %0d want 61", bus.meta_count_o);
    end
    cycle(1, 32'hABC0, 4'h1, 1, 32'hDEF0, 4'h2, 1, 0);
    vectors++;
    if ({s_arready, s_awready} !== 2'b10) begin
      miscompares++; $display("FAIL af_resume: got %b want 10", {s_arready, s_awready});
    end
    expect_accept(1'b0, 4'h1, 32'hABC0);
    while (exp_q.size() > 0) begin
      cycle(0, '0, '0, 0, '0, '0, 1, 1);
      e = exp_q.pop_front(); b_count--;
      vectors++;
      if (s_head !== e) begin
        miscompares++; $display("FAIL af_order: got %h want %h", s_head, e);
      end
      vectors++;
      if ({bus.meta_aempty_o, bus.meta_empty_o, bus.meta_count_o} !==
          {b_count <= 2, b_count == 0, 7'(b_count)}) begin
        miscompares++;
        $display("FAIL af_drain_flags: got %b/%b/%0d want count %0d",
                 bus.meta_aempty_o, bus.meta_empty_o, bus.meta_count_o, b_count);
      end
    end
  endtask

  task automatic test_tid_wrap();
    meta_entry_t e;
    logic [AW-1:0] ara, awa;
    logic [IW-1:0] rid, wid;
    logic odd, had;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      ara = $urandom(); awa = $urandom();
      rid = IW'($urandom_range(0, 15)); wid = IW'($urandom_range(0, 15));
      odd = (i % 2) == 1;
      had = exp_q.size() > 0;
      cycle(~odd, ara, rid, odd, awa, wid, 1, 1);
      vectors++;
      if ({s_arready, s_awready} !== {~odd, odd}) begin
        miscompares++; $display("FAIL wrap_grant%0d: got %b want %b", i, {s_arready, s_awready}, {~odd, odd});
      end
      if (had) begin
        e = exp_q.pop_front(); b_count--;
        vectors++;
        if (s_head !== e) begin
          miscompares++; $display("FAIL wrap_order%0d: got %h want %h", i, s_head, e);
        end
      end
      expect_accept(odd, odd ? wid : rid, odd ? awa : ara);
    end
    vectors++;
    if (bus.meta_count_o !== 7'd1) begin
      miscompares++; $display("FAIL wrap_count: got %0d want 1", bus.meta_count_o);
    end
    cycle(0, '0, '0, 0, '0, '0, 1, 1);
    e = exp_q.pop_front(); b_count--;
    vectors++;
    if (s_head !== e || e.tid !== 6'd5) begin
      miscompares++; $display("FAIL wrap_last: got %h want %h (tid 5)", s_head, e);
    end
  endtask

  task automatic test_reset_mid();
    meta_entry_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'h9000 + 32'(i), 4'h4, 0, '0, '0, 1, 0);
      expect_accept(1'b0, 4'h4, 32'h9000 + 32'(i));
    end
    vectors++;
    if ({bus.arvalid_o, bus.meta_count_o} !== {1'b1, 7'd5}) begin
      miscompares++; $display("FAIL rm_pre: got %b/%0d want 1/5", bus.arvalid_o, bus.meta_count_o);
    end
    rst = 1'b1;
    cycle(1, 32'h5555, 4'h1, 1, 32'h6666, 4'h2, 1, 1);
    rst = 1'b0;
    exp_q.delete(); b_tid = '0; b_count = 0;
    vectors++;
    if ({s_arready, s_awready} !== 2'b00) begin
      miscompares++; $display("FAIL rm_no_handshake: got %b want 00", {s_arready, s_awready});
    end
    vectors++;
    if ({bus.arvalid_o, bus.meta_empty_o, bus.meta_aempty_o, bus.meta_count_o} !== {3'b011, 7'd0}) begin
      miscompares++;
      $display("FAIL rm_cleared: got %b%b%b/%0d want 011/0",
               bus.arvalid_o, bus.meta_empty_o, bus.meta_aempty_o, bus.meta_count_o);
    end
    cycle(0, '0, '0, 1, 32'h7788, 4'h9, 1, 0);
    vectors++;
    if ({s_arready, s_awready} !== 2'b01) begin
      miscompares++; $display("FAIL rm_aw: got %b want 01", {s_arready, s_awready});
    end
    expect_accept(1'b1, 4'h9, 32'h7788);
    e = exp_q.pop_front(); b_count--;
    vectors++;
    if (bus.meta_rdata_o !== e) begin
      miscompares++; $display("FAIL rm_tid_restart: got %h want %h", bus.meta_rdata_o, e);
    end
    cycle(0, '0, '0, 0, '0, '0, 1, 1);
  endtask

  initial begin
    bus.arvalid_i = 1'b0; bus.araddr_i = '0; bus.arid_i = '0;
    bus.awvalid_i = 1'b0; bus.awaddr_i = '0; bus.awid_i = '0;
    bus.arready_i = 1'b1; bus.meta_rden_i = 1'b0;
    b_tid = '0;
    b_count = 0;
    test_reset();
    test_single_ar();
    test_round_robin();
    test_backpressure();
    test_almost_full();
    test_tid_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
